// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encodings and default widths.
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BANK_W_DEF = 2;
    localparam int DQ_W_DEF   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

endpackage

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: grants init / refresh / write / read one at a time and
// muxes the granted source onto the SDRAM pins.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BANK_W = BANK_W_DEF,
    parameter int DQ_W   = DQ_W_DEF,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              flag_aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              flag_wr_end,
    input  logic              wr_flag_aref,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic              flag_rd_end,
    input  logic              rd_flag_aref,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_o,
    output logic              sdram_dq_oe
);

    state_t state;
    gnt_t   last_gnt;
    logic   pick_rd;
    logic [3:0] cmd;

    // On a wr/rd tie, round-robin gives the turn to whoever did not go last.
    assign pick_rd = RR_EN && (last_gnt == GNT_WR);

    // Grant FSM; every grant returns through ARBIT, so grants are never back-to-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            last_gnt <= GNT_RD;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (init_end) state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (aref_req) begin
                        state <= ST_AREF;
                    end else if (wr_req && rd_req) begin
                        if (pick_rd) begin
                            state    <= ST_READ;
                            last_gnt <= GNT_RD;
                        end else begin
                            state    <= ST_WRITE;
                            last_gnt <= GNT_WR;
                        end
                    end else if (wr_req) begin
                        state    <= ST_WRITE;
                        last_gnt <= GNT_WR;
                    end else if (rd_req) begin
                        state    <= ST_READ;
                        last_gnt <= GNT_RD;
                    end
                end
                ST_AREF: begin
                    if (flag_aref_end) state <= ST_ARBIT;
                end
                ST_WRITE: begin
                    if (flag_wr_end || wr_flag_aref) state <= ST_ARBIT;
                end
                ST_READ: begin
                    if (flag_rd_end || rd_flag_aref) state <= ST_ARBIT;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Grant levels decode straight from the state register.
    assign aref_en   = (state == ST_AREF);
    assign wr_en     = (state == ST_WRITE);
    assign rd_en     = (state == ST_READ);
    assign sdram_cke = 1'b1;

    // Bus mux from the state register; sources are already registered upstream.
    always_comb begin
        cmd        = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        unique case (state)
            ST_INIT: begin
                cmd        = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd        = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd        = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                cmd        = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                cmd        = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = '0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    // DQ is driven only while the write block owns the bus.
    assign sdram_dq_oe = (state == ST_WRITE);
    assign sdram_dq_o  = sdram_dq_oe ? wr_data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: two instances (round-robin and
// fixed priority) share all inputs and are compared against a bus-ownership model.
module tb_sdram_arbiter;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int DQ_W   = 16;

    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_AREF = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic init_end;
    logic [3:0] init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic [BANK_W-1:0] wr_bank, rd_bank;
    logic [DQ_W-1:0] wr_data;
    logic aref_req, flag_aref_end, wr_req, flag_wr_end, wr_flag_aref;
    logic rd_req, flag_rd_end, rd_flag_aref;

    // index 0: RR_EN=1, index 1: RR_EN=0
    logic aref_en[2], wr_en[2], rd_en[2], s_cke[2];
    logic s_cs_n[2], s_ras_n[2], s_cas_n[2], s_we_n[2];
    logic [BANK_W-1:0] s_bank[2];
    logic [ADDR_W-1:0] s_addr[2];
    logic [DQ_W-1:0] s_dq_o[2];
    logic s_dq_oe[2];

    int errors = 0;
    int checks = 0;

    int own[2];
    bit last_wr[2];

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .flag_aref_end(flag_aref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .flag_wr_end(flag_wr_end), .wr_flag_aref(wr_flag_aref),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .flag_rd_end(flag_rd_end), .rd_flag_aref(rd_flag_aref),
        .aref_en(aref_en[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .sdram_cke(s_cke[0]),
        .sdram_cs_n(s_cs_n[0]), .sdram_ras_n(s_ras_n[0]), .sdram_cas_n(s_cas_n[0]), .sdram_we_n(s_we_n[0]),
        .sdram_bank(s_bank[0]), .sdram_addr(s_addr[0]), .sdram_dq_o(s_dq_o[0]), .sdram_dq_oe(s_dq_oe[0])
    );

    sdram_arbiter #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .flag_aref_end(flag_aref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .flag_wr_end(flag_wr_end), .wr_flag_aref(wr_flag_aref),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .flag_rd_end(flag_rd_end), .rd_flag_aref(rd_flag_aref),
        .aref_en(aref_en[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .sdram_cke(s_cke[1]),
        .sdram_cs_n(s_cs_n[1]), .sdram_ras_n(s_ras_n[1]), .sdram_cas_n(s_cas_n[1]), .sdram_we_n(s_we_n[1]),
        .sdram_bank(s_bank[1]), .sdram_addr(s_addr[1]), .sdram_dq_o(s_dq_o[1]), .sdram_dq_oe(s_dq_oe[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] en_of(input int k);
        return {aref_en[k], wr_en[k], rd_en[k]};
    endfunction

    function automatic logic [3:0] cmd_of(input int k);
        return {s_cs_n[k], s_ras_n[k], s_cas_n[k], s_we_n[k]};
    endfunction

    function automatic logic [39:0] dut_pins(input int k);
        return {en_of(k), s_cke[k], cmd_of(k), s_bank[k], s_addr[k], s_dq_oe[k], s_dq_o[k]};
    endfunction

    // Who owns the bus decides everything visible on the pins.
    function automatic logic [39:0] model_pins(input int k);
        logic [3:0] c;
        logic [ADDR_W-1:0] a;
        logic [BANK_W-1:0] b;
        logic [2:0] e;
        c = 4'b0111; a = '0; b = '0; e = 3'b000;
        case (own[k])
            O_INIT: begin c = init_cmd; a = init_addr; end
            O_AREF: begin c = aref_cmd; a = aref_addr; e = 3'b100; end
            O_WR:   begin c = wr_cmd; a = wr_addr; b = wr_bank; e = 3'b010; end
            O_RD:   begin c = rd_cmd; a = rd_addr; b = rd_bank; e = 3'b001; end
            default: ;
        endcase
        return {e, 1'b1, c, b, a, (own[k] == O_WR), (own[k] == O_WR) ? wr_data : 16'h0000};
    endfunction

    function automatic void model_step(input int k);
        bit give_wr;
        if (!rst_n) begin
            own[k] = O_INIT;
            last_wr[k] = 1'b0;
        end else if (own[k] == O_INIT) begin
            if (init_end) own[k] = O_IDLE;
        end else if (own[k] == O_IDLE) begin
            if (aref_req) begin
                own[k] = O_AREF;
            end else if (wr_req || rd_req) begin
                // round-robin instance hands a tie to read only if write went last
                give_wr = wr_req && !(rd_req && k == 0 && last_wr[k]);
                own[k] = give_wr ? O_WR : O_RD;
                last_wr[k] = give_wr;
            end
        end else if (own[k] == O_AREF) begin
            if (flag_aref_end) own[k] = O_IDLE;
        end else if (own[k] == O_WR) begin
            if (flag_wr_end || wr_flag_aref) own[k] = O_IDLE;
        end else begin
            if (flag_rd_end || rd_flag_aref) own[k] = O_IDLE;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        chk("pins_rr", {24'h0, dut_pins(0)}, {24'h0, model_pins(0)});
        chk("pins_fp", {24'h0, dut_pins(1)}, {24'h0, model_pins(1)});
    endtask

    task automatic clear_reqs();
        {aref_req, wr_req, rd_req, flag_aref_end, flag_wr_end, wr_flag_aref, flag_rd_end, rd_flag_aref} = '0;
    endtask

    typedef struct {
        logic [7:0] req;   // {aref, wr, rd, aref_end, wr_end, wr_flag_aref, rd_end, rd_flag_aref}
        logic [2:0] en_rr; // {aref_en, wr_en, rd_en} after the edge, RR_EN=1
        logic [2:0] en_fp; // same, RR_EN=0
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{8'b111_00000, 3'b100, 3'b100};
        tbl[1]  = '{8'b011_00000, 3'b100, 3'b100};
        tbl[2]  = '{8'b011_10000, 3'b000, 3'b000};
        tbl[3]  = '{8'b011_00000, 3'b010, 3'b010};
        tbl[4]  = '{8'b011_00000, 3'b010, 3'b010};
        tbl[5]  = '{8'b111_00000, 3'b010, 3'b010};
        tbl[6]  = '{8'b111_00000, 3'b010, 3'b010};
        tbl[7]  = '{8'b111_00100, 3'b000, 3'b000};
        tbl[8]  = '{8'b111_00000, 3'b100, 3'b100};
        tbl[9]  = '{8'b011_10000, 3'b000, 3'b000};
        tbl[10] = '{8'b011_00000, 3'b001, 3'b010};
        tbl[11] = '{8'b011_00010, 3'b000, 3'b010};
        tbl[12] = '{8'b011_00000, 3'b010, 3'b010};
        tbl[13] = '{8'b011_01000, 3'b000, 3'b000};
        tbl[14] = '{8'b011_00000, 3'b001, 3'b010};
        tbl[15] = '{8'b011_00001, 3'b000, 3'b010};
        tbl[16] = '{8'b000_10000, 3'b000, 3'b010};
        tbl[17] = '{8'b000_01000, 3'b000, 3'b000};
        tbl[18] = '{8'b001_00000, 3'b001, 3'b001};
        tbl[19] = '{8'b001_01000, 3'b001, 3'b001};
        tbl[20] = '{8'b000_00010, 3'b000, 3'b000};

        own[0] = O_INIT; own[1] = O_INIT;
        last_wr[0] = 1'b0; last_wr[1] = 1'b0;
        rst_n = 1'b0; init_end = 1'b0;
        init_cmd = 4'b0010; init_addr = 13'h0400;
        aref_cmd = 4'b0001; aref_addr = 13'h0000;
        wr_cmd = 4'b0100; wr_addr = 13'h0123; wr_bank = 2'd2; wr_data = 16'hBEEF;
        rd_cmd = 4'b0101; rd_addr = 13'h0456; rd_bank = 2'd1;
        clear_reqs();

        // reset, then init_end rises at cycle 10
        tick(); tick();
        chk("reset_en", {61'h0, en_of(0)}, 64'h0);
        chk("reset_oe", {63'h0, s_dq_oe[0]}, 64'h0);
        chk("reset_cke", {63'h0, s_cke[0]}, 64'h1);
        chk("reset_cmd", {60'h0, cmd_of(0)}, 64'h2);
        rst_n = 1'b1;
        for (int c = 1; c < 10; c++) begin
            tick();
            chk("init_wait_en", {61'h0, en_of(0)}, 64'h0);
        end
        init_end = 1'b1;
        tick();
        chk("arbit_nop", {60'h0, cmd_of(0)}, 64'h7);
        chk("arbit_addr", {51'h0, s_addr[0]}, 64'h0);
        chk("arbit_bank", {62'h0, s_bank[0]}, 64'h0);
        chk("arbit_en", {61'h0, en_of(0)}, 64'h0);

        // table: priority, no preemption, round-robin vs fixed, stale end pulses
        for (int i = 0; i < 21; i++) begin
            {aref_req, wr_req, rd_req, flag_aref_end, flag_wr_end, wr_flag_aref, flag_rd_end, rd_flag_aref} = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_rr", i), {61'h0, en_of(0)}, {61'h0, tbl[i].en_rr});
            chk($sformatf("tbl%0d_fp", i), {61'h0, en_of(1)}, {61'h0, tbl[i].en_fp});
        end
        clear_reqs();

        // write drives DQ
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("wr_dq_oe", {63'h0, s_dq_oe[0]}, 64'h1);
        chk("wr_dq_o", {48'h0, s_dq_o[0]}, 64'hBEEF);
        chk("wr_bank", {62'h0, s_bank[0]}, 64'h2);
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk("wr_end_oe", {63'h0, s_dq_oe[0]}, 64'h0);
        chk("wr_end_dq", {48'h0, s_dq_o[0]}, 64'h0);

        // reset in the middle of a read
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("read_en", {61'h0, en_of(0)}, 64'h1);
        rst_n = 1'b0; init_end = 1'b0; init_cmd = 4'b0111;
        tick();
        chk("midrst_en", {61'h0, en_of(0)}, 64'h0);
        chk("midrst_cmd", {60'h0, cmd_of(0)}, 64'h7);
        chk("midrst_addr", {51'h0, s_addr[0]}, 64'h0400);
        rst_n = 1'b1;
        tick();
        init_end = 1'b1;
        tick();

        // randomized traffic against the ownership model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            init_end = ($urandom_range(0, 7) != 0);
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_cmd = 4'($urandom); wr_addr = 13'($urandom); wr_bank = 2'($urandom); wr_data = 16'($urandom);
            rd_cmd = 4'($urandom); rd_addr = 13'($urandom); rd_bank = 2'($urandom);
            aref_req = ($urandom_range(0, 7) == 0);
            wr_req = ($urandom_range(0, 2) == 0);
            rd_req = ($urandom_range(0, 2) == 0);
            flag_aref_end = ($urandom_range(0, 4) == 0);
            flag_wr_end = ($urandom_range(0, 5) == 0);
            wr_flag_aref = ($urandom_range(0, 9) == 0);
            flag_rd_end = ($urandom_range(0, 5) == 0);
            rd_flag_aref = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
